// File: rtl/clause_queue_pkg.sv
// rtl/clause_queue_pkg.sv - shared solver types: clause record and default clause queue depth
package clause_queue_pkg;

  // Default number of clause entries in a clause queue
  localparam int CLQ_DEPTH = 8;

  // One clause as it travels from the switch to the engine
  typedef struct packed {
    logic [15:0] id;
    logic [15:0] lit;
  } cla_t;

endpackage

// File: rtl/clause_queue.sv
// rtl/clause_queue.sv - show-ahead circular clause queue; optional drop counter under CLQ_DROP_CNT_EN
module clause_queue
  import clause_queue_pkg::*;
#(
  parameter int DEPTH = CLQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  cla_t                       sw2clq,
  input  logic                       sw2clq_valid,
  output cla_t                       clq2eng,
  output logic                       clq2eng_valid,
  input  logic                       eng2clq_ready,
  output logic                       clq2carb_full,
  output logic [$clog2(DEPTH+1)-1:0] clq_count
`ifdef CLQ_DROP_CNT_EN
  ,
  output logic [15:0]                clq_drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cla_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Flags come only from the registered count; full rejects a push even when a pop happens alongside
  always_comb begin
    clq2eng_valid = (count != '0);
    clq2carb_full = (count == CW'(DEPTH));
    push          = sw2clq_valid && !clq2carb_full;
    pop           = clq2eng_valid && eng2clq_ready;
    clq2eng       = mem[rd_ptr];
    clq_count     = count;
  end

  // Storage write; contents are never reset, stale entries are masked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sw2clq;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef CLQ_DROP_CNT_EN
  // Count push requests turned away while full, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clq_drop_cnt <= '0;
    end else if (sw2clq_valid && clq2carb_full && (clq_drop_cnt != 16'hFFFF)) begin
      clq_drop_cnt <= clq_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clause_queue.sv
// tb/tb_clause_queue.sv - directed self-checking bench for clause_queue at DEPTH=4
module tb_clause_queue;
  import clause_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  cla_t       sw2clq = '0;
  logic       sw2clq_valid = 1'b0;
  cla_t       clq2eng;
  logic       clq2eng_valid;
  logic       eng2clq_ready = 1'b0;
  logic       clq2carb_full;
  logic [2:0] clq_count;
`ifdef CLQ_DROP_CNT_EN
  logic [15:0] clq_drop_cnt;
`endif

  int cmps = 0;
  int errs = 0;

  clause_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw2clq        (sw2clq),
    .sw2clq_valid  (sw2clq_valid),
    .clq2eng       (clq2eng),
    .clq2eng_valid (clq2eng_valid),
    .eng2clq_ready (eng2clq_ready),
    .clq2carb_full (clq2carb_full),
    .clq_count     (clq_count)
`ifdef CLQ_DROP_CNT_EN
    ,
    .clq_drop_cnt  (clq_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic cla_t mk(input logic [15:0] n);
    cla_t c;
    c.id  = n;
    c.lit = ~n;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sw2clq_valid  = 1'b0;
    eng2clq_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    eng2clq_ready = 1'b1;
    repeat (n) step();
    eng2clq_ready = 1'b0;
  endtask

  task automatic push_seq(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      sw2clq       = mk(first + 16'(i));
      sw2clq_valid = 1'b1;
      step();
    end
    sw2clq_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq2carb_full !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL reset_state: valid=%b full=%b count=%0d expected 0/0/0", clq2eng_valid, clq2carb_full, clq_count);
      errs++;
    end
`ifdef CLQ_DROP_CNT_EN
    cmps++;
    if (clq_drop_cnt !== 16'd0) begin
      $display("FAIL reset_drop: got %0d expected 0", clq_drop_cnt);
      errs++;
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    sw2clq       = mk(16'hA);
    sw2clq_valid = 1'b1;
    step();
    sw2clq_valid = 1'b0;
    cmps++;
    if (clq2eng_valid !== 1'b1 || clq2eng !== mk(16'hA) || clq_count !== 3'd1) begin
      $display("FAIL single_push: valid=%b data=%h count=%0d expected 1/%h/1", clq2eng_valid, clq2eng, clq_count, mk(16'hA));
      errs++;
    end
    drain(1);
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL single_pop: valid=%b count=%0d expected 0/0", clq2eng_valid, clq_count);
      errs++;
    end
  endtask

  task automatic test_fill();
    push_seq(16'h100, 4);
    cmps++;
    if (clq2carb_full !== 1'b1 || clq_count !== 3'd4) begin
      $display("FAIL fill_full: full=%b count=%0d expected 1/4", clq2carb_full, clq_count);
      errs++;
    end
    push_seq(16'h1EE, 1);
    cmps++;
    if (clq_count !== 3'd4 || clq2eng !== mk(16'h100)) begin
      $display("FAIL fill_reject: count=%0d head=%h expected 4/%h", clq_count, clq2eng, mk(16'h100));
      errs++;
    end
    eng2clq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmps++;
      if (clq2eng_valid !== 1'b1 || clq2eng !== mk(16'h100 + 16'(i))) begin
        $display("FAIL fill_order%0d: valid=%b head=%h expected 1/%h", i, clq2eng_valid, clq2eng, mk(16'h100 + 16'(i)));
        errs++;
      end
      step();
    end
    eng2clq_ready = 1'b0;
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL fill_empty: valid=%b count=%0d expected 0/0", clq2eng_valid, clq_count);
      errs++;
    end
  endtask

  task automatic test_full_push_pop();
`ifdef CLQ_DROP_CNT_EN
    logic [15:0] drops;
`endif
    push_seq(16'h200, 4);
`ifdef CLQ_DROP_CNT_EN
    drops = clq_drop_cnt;
`endif
    sw2clq        = mk(16'h2FF);
    sw2clq_valid  = 1'b1;
    eng2clq_ready = 1'b1;
    step();
    idle();
    cmps++;
    if (clq_count !== 3'd3 || clq2carb_full !== 1'b0 || clq2eng !== mk(16'h201)) begin
      $display("FAIL fullpp_state: count=%0d full=%b head=%h expected 3/0/%h", clq_count, clq2carb_full, clq2eng, mk(16'h201));
      errs++;
    end
`ifdef CLQ_DROP_CNT_EN
    cmps++;
    if (clq_drop_cnt !== drops + 16'd1) begin
      $display("FAIL fullpp_drop: got %0d expected %0d", clq_drop_cnt, drops + 16'd1);
      errs++;
    end
`endif
    eng2clq_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cmps++;
      if (clq2eng_valid !== 1'b1 || clq2eng !== mk(16'h200 + 16'(i))) begin
        $display("FAIL fullpp_order%0d: valid=%b head=%h expected 1/%h", i, clq2eng_valid, clq2eng, mk(16'h200 + 16'(i)));
        errs++;
      end
      step();
    end
    eng2clq_ready = 1'b0;
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL fullpp_empty: valid=%b count=%0d expected 0/0", clq2eng_valid, clq_count);
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    push_seq(16'h300, 2);
    for (int k = 0; k < 10; k++) begin
      sw2clq        = mk(16'h302 + 16'(k));
      sw2clq_valid  = 1'b1;
      eng2clq_ready = 1'b1;
      cmps++;
      if (clq2eng !== mk(16'h300 + 16'(k))) begin
        $display("FAIL b2b_head%0d: got %h expected %h", k, clq2eng, mk(16'h300 + 16'(k)));
        errs++;
      end
      step();
      cmps++;
      if (clq_count !== 3'd2) begin
        $display("FAIL b2b_count%0d: got %0d expected 2", k, clq_count);
        errs++;
      end
    end
    idle();
    eng2clq_ready = 1'b1;
    for (int k = 10; k < 12; k++) begin
      cmps++;
      if (clq2eng !== mk(16'h300 + 16'(k))) begin
        $display("FAIL b2b_tail%0d: got %h expected %h", k, clq2eng, mk(16'h300 + 16'(k)));
        errs++;
      end
      step();
    end
    eng2clq_ready = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    eng2clq_ready = 1'b1;
    repeat (2) step();
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL empty_pop: valid=%b count=%0d expected 0/0", clq2eng_valid, clq_count);
      errs++;
    end
    sw2clq       = mk(16'h400);
    sw2clq_valid = 1'b1;
    step();
    idle();
    cmps++;
    if (clq2eng_valid !== 1'b1 || clq_count !== 3'd1 || clq2eng !== mk(16'h400)) begin
      $display("FAIL empty_pushpop: valid=%b count=%0d head=%h expected 1/1/%h", clq2eng_valid, clq_count, clq2eng, mk(16'h400));
      errs++;
    end
    drain(1);
  endtask

  task automatic test_async_reset();
    push_seq(16'h500, 3);
    cmps++;
    if (clq_count !== 3'd3) begin
      $display("FAIL areset_pre: count=%0d expected 3", clq_count);
      errs++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0 || clq2carb_full !== 1'b0) begin
      $display("FAIL areset_now: valid=%b count=%0d full=%b expected 0/0/0", clq2eng_valid, clq_count, clq2carb_full);
      errs++;
    end
    step();
    rst_n = 1'b1;
    step();
    cmps++;
    if (clq2eng_valid !== 1'b0 || clq_count !== 3'd0) begin
      $display("FAIL areset_after: valid=%b count=%0d expected 0/0", clq2eng_valid, clq_count);
      errs++;
    end
    push_seq(16'h5AA, 1);
    cmps++;
    if (clq_count !== 3'd1 || clq2eng !== mk(16'h5AA)) begin
      $display("FAIL areset_reuse: count=%0d head=%h expected 1/%h", clq_count, clq2eng, mk(16'h5AA));
      errs++;
    end
    drain(1);
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_empty_push_pop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/clause_queue.md
CLAUSE_QUEUE -- requirements
Module: clause_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of clause entries; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port sw2clq, input, type cla_t, the clause delivered by the switch.
REQ-005 The block SHALL have port sw2clq_valid, input, width 1, which qualifies sw2clq as a push request.
REQ-006 The block SHALL have port clq2eng, output, type cla_t, the head-of-queue clause presented to the engine.
REQ-007 The block SHALL have port clq2eng_valid, output, width 1, which is high whenever the queue holds at least one clause.
REQ-008 The block SHALL have port eng2clq_ready, input, width 1, the engine's acceptance of the head clause.
REQ-009 The block SHALL have port clq2carb_full, output, width 1, backpressure to the clause arbiter.
REQ-010 The block SHALL have port clq_count, output, width $clog2(DEPTH+1), the current occupancy.

Function
REQ-011 The queue SHALL be a circular buffer of DEPTH cla_t entries, with write pointer, read pointer and count registers.
REQ-012 A push SHALL occur on a cycle where sw2clq_valid=1 and clq2carb_full=0, storing sw2clq at the write pointer.
REQ-013 A pop SHALL occur on a cycle where clq2eng_valid=1 and eng2clq_ready=1, advancing the read pointer.
REQ-014 The queue SHALL present the head in show-ahead form: clq2eng equals the entry at the read pointer, and clq2eng_valid = (count != 0).
REQ-015 Push-to-output latency SHALL be 1 cycle with no combinational bypass; a clause pushed into an empty queue appears on clq2eng in the next cycle.
REQ-016 Full and empty flags SHALL derive from the registered count only: clq2carb_full = (count == DEPTH).
REQ-017 A push request while full SHALL be rejected, even if a pop occurs in the same cycle; the stored contents and count stay unchanged by that request.
REQ-018 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-019 A pop request while empty SHALL be ignored, with no pointer movement.
REQ-020 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL never exceed DEPTH or go below 0.
REQ-022 clq2eng SHALL be don't-care while clq2eng_valid=0.

Reset
REQ-023 While rst_n=0 the block SHALL clear the pointers and count to 0, forcing clq2eng_valid=0, clq2carb_full=0 and clq_count=0.
REQ-024 Reset asserted mid-operation SHALL discard all queued clauses immediately and asynchronously.
REQ-025 Storage array contents SHALL NOT require reset.
REQ-026 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro CLQ_DROP_CNT_EN defined, the block SHALL add output clq_drop_cnt, width 16, which counts push requests rejected under REQ-017.
REQ-028 clq_drop_cnt SHALL saturate at 16'hFFFF and reset to 0.
REQ-029 Without CLQ_DROP_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 cla_t SHALL come from the shared solver package, which also holds the default depth constant CLQ_DEPTH=8.
REQ-031 No sub-module SHALL be required; storage, pointers and count SHALL be local to clause_queue.

Verification (DEPTH=4)
REQ-032 Reset, then push clause A for one cycle -> next cycle clq2eng_valid=1, clq2eng=A, clq_count=1.
REQ-033 Push A, B, C, D on consecutive cycles with ready=0 -> clq2carb_full=1 and clq_count=4; a fifth push E is rejected; popping 4 times yields A, B, C, D in order.
REQ-034 With the queue full, assert push F and pop in the same cycle -> A pops, F is rejected, clq_count=3; with CLQ_DROP_CNT_EN defined, clq_drop_cnt increments by 1.
REQ-035 With count=2, push and pop every cycle for 10 cycles -> clq_count stays 2, pointers wrap, and the output order matches the input order.
REQ-036 On an empty queue, assert push and ready together -> no pop occurs, and the next cycle shows clq2eng_valid=1 with clq_count=1.
REQ-037 Assert rst_n=0 mid-stream with count=3 -> clq2eng_valid=0 and clq_count=0 without waiting for a clock edge; after release, the queue behaves as empty.
